// File: rtl/frame_uploader_pkg.sv
// Shared types and constants for the frame burst uploader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package frame_uploader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        WAIT_ROW,
        FILL,
        REQ,
        WRITE,
        DONE
    } t_state;

    // Marker codes carried in the low bits of a queue entry whose MSB is set.
    localparam int MARKER_FRAME_START = 0;
    localparam int MARKER_ROW_START   = 1;

    // Pixels packed into one memory word.
    function automatic int calc_ppw(input int data_width, input int pixel_width);
        return data_width / pixel_width;
    endfunction

endpackage

// File: rtl/burst_pack_buffer.sv
// Packs pixels into memory words and holds one burst of words for readout.
// Latency: a word is readable the cycle after its last pixel; read data is registered, 1 cycle after rd_vld.
// Backpressure: none internally; the owner stops pushing once fill_last fires and clears after the burst.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   pix_vld/_dat   push one pixel (first pixel of a word lands in the LSBs)
//   flush          close the partial word (zero padded); unwritten words read back as zero
//   clear          empty the buffer for the next burst
//   fill_last      the pixel pushed this cycle completes the burst
//   buf_empty      no pixel held, no word written
//   rd_vld/rd_idx  read request for word rd_idx; rd_dat valid next cycle
module burst_pack_buffer
    import frame_uploader_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int PIXEL_WIDTH = 16,
    parameter int BURST_WORDS = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           pix_vld,
    input  logic [PIXEL_WIDTH-1:0]         pix_dat,
    input  logic                           flush,
    input  logic                           clear,
    output logic                           fill_last,
    output logic                           buf_empty,
    input  logic                           rd_vld,
    input  logic [$clog2(BURST_WORDS)-1:0] rd_idx,
    output logic [DATA_WIDTH-1:0]          rd_dat
);

    localparam int PPW    = calc_ppw(DATA_WIDTH, PIXEL_WIDTH);
    localparam int IDX_W  = $clog2(BURST_WORDS);
    localparam int SLOT_W = (PPW > 1) ? $clog2(PPW) : 1;

    logic [DATA_WIDTH-1:0] mem [BURST_WORDS];
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] acc_nxt;
    logic [DATA_WIDTH-1:0] commit_word;
    logic [SLOT_W-1:0]     slot;
    logic [IDX_W:0]        wr_cnt;
    logic                  last_slot;
    logic                  commit;

    always_comb begin
        acc_nxt = acc;
        for (int k = 0; k < PPW; k++) begin
            if (slot == SLOT_W'(k)) begin
                acc_nxt[k*PIXEL_WIDTH +: PIXEL_WIDTH] = pix_dat;
            end
        end
    end

    assign last_slot   = (slot == SLOT_W'(PPW - 1));
    // A flush only commits a word if it actually holds pixels; empty slots are already zero.
    assign commit      = (pix_vld && last_slot) || (!pix_vld && flush && (slot != '0));
    assign commit_word = pix_vld ? acc_nxt : acc;
    assign fill_last   = pix_vld && last_slot && (wr_cnt == (IDX_W+1)'(BURST_WORDS - 1));
    assign buf_empty   = (wr_cnt == '0) && (slot == '0);

    always_ff @(posedge clk) begin
        if (commit) begin
            mem[wr_cnt[IDX_W-1:0]] <= commit_word;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc    <= '0;
            slot   <= '0;
            wr_cnt <= '0;
        end else if (clear) begin
            acc    <= '0;
            slot   <= '0;
            wr_cnt <= '0;
        end else begin
            if (pix_vld) begin
                if (last_slot) begin
                    acc  <= '0;
                    slot <= '0;
                end else begin
                    acc  <= acc_nxt;
                    slot <= slot + SLOT_W'(1);
                end
            end else if (flush) begin
                acc  <= '0;
                slot <= '0;
            end
            if (commit) begin
                wr_cnt <= wr_cnt + (IDX_W+1)'(1);
            end
        end
    end

    // Words beyond the written count read as zero, which is how a short burst gets padded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_dat <= '0;
        end else if (rd_vld) begin
            rd_dat <= ({1'b0, rd_idx} < wr_cnt) ? mem[rd_idx] : '0;
        end
    end

endmodule

// File: rtl/frame_burst_uploader.sv
// Drains a FWFT pixel queue, packs pixels into words and writes a frame to memory in fixed-size bursts.
// Latency: burst request after BURST_WORDS*PPW pixels; data starts 1 cycle after write_ack, BURST_WORDS back-to-back.
// Backpressure: empty queue stalls FILL; no pops while a burst is requested/written; REQ waits on write_ack.
//
// Ports: clk/reset_n; start + base_addr begin a frame; queue_empty/queue_data/rd_en is the FWFT queue;
//   write_rq/write_ack/write_addr is the burst handshake; mem_wr_en/write_data carry the words;
//   upload_done and frame_error are 1-cycle status pulses.
// Option: define FRAME_UPLOADER_ACK_TIMEOUT_EN to abort to IDLE when write_ack does not arrive within ACK_TIMEOUT cycles.
module frame_burst_uploader
    import frame_uploader_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int PIXEL_WIDTH  = 16,
    parameter int BURST_WORDS  = 8,
    parameter int ADDR_WIDTH   = 21,
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int ACK_TIMEOUT  = 1024
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic                   queue_empty,
    input  logic [PIXEL_WIDTH:0]   queue_data,
    output logic                   rd_en,
    output logic                   write_rq,
    input  logic                   write_ack,
    output logic [ADDR_WIDTH-1:0]  write_addr,
    output logic                   mem_wr_en,
    output logic [DATA_WIDTH-1:0]  write_data,
    output logic                   upload_done,
    output logic                   frame_error
);

    localparam int          PPW      = calc_ppw(DATA_WIDTH, PIXEL_WIDTH);
    localparam int          IDX_W    = $clog2(BURST_WORDS);
    localparam logic [10:0] COL_STEP = 11'(BURST_WORDS * PPW);
    localparam logic [10:0] COL_LAST = 11'(FRAME_WIDTH);
    localparam logic [10:0] ROW_LAST = 11'(FRAME_HEIGHT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_WORDS - 1);

    if (DATA_WIDTH % PIXEL_WIDTH != 0) begin : g_bad_dw
        $error("DATA_WIDTH must be a multiple of PIXEL_WIDTH");
    end
    if (BURST_WORDS < 2 || BURST_WORDS > 32 || (BURST_WORDS & (BURST_WORDS - 1)) != 0) begin : g_bad_bw
        $error("BURST_WORDS must be a power of 2 in 2..32");
    end
    if (FRAME_WIDTH % (BURST_WORDS * PPW) != 0) begin : g_bad_fw
        $error("FRAME_WIDTH must be a multiple of BURST_WORDS*PPW");
    end
    if (ACK_TIMEOUT < 1) begin : g_bad_to
        $error("ACK_TIMEOUT must be at least 1");
    end

    t_state                state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [10:0]           col_q;
    logic [10:0]           row_q;
    logic [10:0]           row_nxt;
    logic [10:0]           col_nxt;
    logic [IDX_W-1:0]      rd_ptr;
    logic                  flushed_q;   // current burst was closed early by a marker
    logic                  flush_fs_q;  // ...and that marker was FRAME_START

    logic head_vld, head_fs, head_rs, head_pix;
    logic pix_vld, buf_flush, buf_clear, buf_rd_vld, fill_last, buf_empty;
    logic [IDX_W-1:0] buf_rd_idx;
    logic to_hit;

    always_comb begin
        head_vld = !queue_empty;
        head_pix = head_vld && !queue_data[PIXEL_WIDTH];
        head_fs  = head_vld && queue_data[PIXEL_WIDTH]
                   && (queue_data[PIXEL_WIDTH-1:0] == PIXEL_WIDTH'(MARKER_FRAME_START));
        head_rs  = head_vld && queue_data[PIXEL_WIDTH]
                   && (queue_data[PIXEL_WIDTH-1:0] == PIXEL_WIDTH'(MARKER_ROW_START));
    end

    // rd_en is decoded from the registered state and the queue head so one entry can pop every cycle.
    // In FILL a frame/row marker stays at the head until the partial burst has been written.
    always_comb begin
        rd_en = 1'b0;
        case (state)
            WAIT_FRAME, WAIT_ROW: rd_en = head_vld;
            FILL:                 rd_en = head_vld && !head_fs && !head_rs;
            default:              rd_en = 1'b0;
        endcase
    end

    assign pix_vld    = (state == FILL) && head_pix;
    assign buf_flush  = (state == FILL) && (head_fs || head_rs) && !buf_empty;
    assign buf_clear  = ((state == WRITE) && (rd_ptr == LAST_IDX)) || to_hit;
    // Word 0 is fetched in the ack cycle so data is ready the cycle mem_wr_en rises.
    assign buf_rd_vld = ((state == REQ) && write_ack) || (state == WRITE);
    assign buf_rd_idx = (state == WRITE) ? rd_ptr + IDX_W'(1) : '0;
    assign row_nxt    = row_q + 11'd1;
    assign col_nxt    = col_q + COL_STEP;
    assign write_addr = addr_q;

`ifdef FRAME_UPLOADER_ACK_TIMEOUT_EN
    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt;

    assign to_hit = (state == REQ) && !write_ack && (to_cnt == TO_W'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt <= '0;
        end else if (state == REQ) begin
            to_cnt <= to_cnt + TO_W'(1);
        end else begin
            to_cnt <= '0;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    burst_pack_buffer #(
        .DATA_WIDTH  (DATA_WIDTH),
        .PIXEL_WIDTH (PIXEL_WIDTH),
        .BURST_WORDS (BURST_WORDS)
    ) u_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .pix_vld   (pix_vld),
        .pix_dat   (queue_data[PIXEL_WIDTH-1:0]),
        .flush     (buf_flush),
        .clear     (buf_clear),
        .fill_last (fill_last),
        .buf_empty (buf_empty),
        .rd_vld    (buf_rd_vld),
        .rd_idx    (buf_rd_idx),
        .rd_dat    (write_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            base_q      <= '0;
            addr_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            rd_ptr      <= '0;
            flushed_q   <= 1'b0;
            flush_fs_q  <= 1'b0;
            write_rq    <= 1'b0;
            mem_wr_en   <= 1'b0;
            upload_done <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            upload_done <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q <= base_addr;
                        addr_q <= base_addr;
                        state  <= WAIT_FRAME;
                    end
                end
                WAIT_FRAME: begin
                    if (head_fs) begin
                        row_q <= '0;
                        state <= WAIT_ROW;
                    end
                end
                WAIT_ROW: begin
                    if (head_rs) begin
                        col_q <= '0;
                        state <= FILL;
                    end else if (head_fs) begin
                        row_q       <= '0;
                        addr_q      <= base_q;
                        frame_error <= 1'b1;
                    end
                end
                FILL: begin
                    if (head_fs || head_rs) begin
                        frame_error <= 1'b1;
                        if (buf_empty) begin
                            // Nothing buffered: close the row (or defer a frame restart to WAIT_ROW).
                            col_q <= '0;
                            if (head_fs) begin
                                state <= WAIT_ROW;
                            end else begin
                                row_q <= row_nxt;
                                if (row_nxt == ROW_LAST) begin
                                    upload_done <= 1'b1;
                                    state       <= DONE;
                                end else begin
                                    state <= WAIT_ROW;
                                end
                            end
                        end else begin
                            flushed_q  <= 1'b1;
                            flush_fs_q <= head_fs;
                            write_rq   <= 1'b1;
                            state      <= REQ;
                        end
                    end else if (fill_last) begin
                        write_rq <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (write_ack) begin
                        write_rq  <= 1'b0;
                        mem_wr_en <= 1'b1;
                        rd_ptr    <= '0;
                        state     <= WRITE;
                    end else if (to_hit) begin
                        write_rq    <= 1'b0;
                        frame_error <= 1'b1;
                        flushed_q   <= 1'b0;
                        flush_fs_q  <= 1'b0;
                        state       <= IDLE;
                    end
                end
                WRITE: begin
                    if (rd_ptr == LAST_IDX) begin
                        mem_wr_en  <= 1'b0;
                        addr_q     <= addr_q + ADDR_WIDTH'(BURST_WORDS);
                        flushed_q  <= 1'b0;
                        flush_fs_q <= 1'b0;
                        if (flush_fs_q) begin
                            // The pending FRAME_START is popped and handled by WAIT_ROW.
                            col_q <= '0;
                            state <= WAIT_ROW;
                        end else if (flushed_q || (col_nxt == COL_LAST)) begin
                            col_q <= '0;
                            row_q <= row_nxt;
                            if (row_nxt == ROW_LAST) begin
                                upload_done <= 1'b1;
                                state       <= DONE;
                            end else begin
                                state <= WAIT_ROW;
                            end
                        end else begin
                            col_q <= col_nxt;
                            state <= FILL;
                        end
                    end else begin
                        rd_ptr <= rd_ptr + IDX_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_burst_uploader.sv
// Directed bench for frame_burst_uploader: queue and arbiter models drive the DUT,
// expected bursts are queued when stimulus is issued and a monitor checks every written word.
module tb_frame_burst_uploader;

    localparam int DW = 32, PW = 16, BW = 8, AW = 21, FW = 32, FH = 2, TO = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          queue_empty = 1'b1;
    logic [PW:0]   queue_data = '0;
    logic          rd_en;
    logic          write_rq;
    logic          write_ack = 1'b0;
    logic [AW-1:0] write_addr;
    logic          mem_wr_en;
    logic [DW-1:0] write_data;
    logic          upload_done;
    logic          frame_error;

    frame_burst_uploader #(
        .DATA_WIDTH(DW), .PIXEL_WIDTH(PW), .BURST_WORDS(BW), .ADDR_WIDTH(AW),
        .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .ACK_TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .queue_empty(queue_empty), .queue_data(queue_data), .rd_en(rd_en),
        .write_rq(write_rq), .write_ack(write_ack), .write_addr(write_addr),
        .mem_wr_en(mem_wr_en), .write_data(write_data),
        .upload_done(upload_done), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int ack_delay = 3;
    bit ack_enable = 1'b1;
    int done_cnt = 0, err_cnt = 0, rd_cnt = 0, rq_total = 0;

    logic [PW:0]   q[$];
    logic [DW-1:0] exp_word[$];
    logic [AW-1:0] exp_addr[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [PW:0] pix(input int v);
        return {1'b0, v[PW-1:0]};
    endfunction

    function automatic logic [PW:0] mark(input int code);
        return {1'b1, code[PW-1:0]};
    endfunction

    task automatic push_pixels(input int first, input int n);
        for (int i = 0; i < n; i++) q.push_back(pix(first + i));
    endtask

    // One expected burst: npix pixels counting up from 'first', zero beyond them.
    task automatic expect_burst(input logic [AW-1:0] addr, input int first, input int npix);
        logic [PW-1:0] lo, hi;
        exp_addr.push_back(addr);
        for (int w = 0; w < BW; w++) begin
            lo = (2*w < npix)     ? PW'(first + 2*w)     : '0;
            hi = (2*w + 1 < npix) ? PW'(first + 2*w + 1) : '0;
            exp_word.push_back({hi, lo});
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // FWFT queue model: rd_en is sampled mid-cycle, the head updates just after the edge.
    initial begin
        bit pop_now;
        forever begin
            @(negedge clk);
            pop_now = rd_en;
            @(posedge clk);
            #1;
            if (pop_now && q.size() > 0) void'(q.pop_front());
            queue_empty = (q.size() == 0);
            queue_data  = (q.size() > 0) ? q[0] : '0;
        end
    end

    // Arbiter model: write_ack pulses in the ack_delay-th cycle of write_rq.
    initial forever begin
        @(posedge clk);
        #1;
        if (write_rq && ack_enable) begin
            repeat (ack_delay - 1) @(posedge clk);
            #1 write_ack = 1'b1;
            @(posedge clk);
            #1 write_ack = 1'b0;
        end
    end

    // Monitor: pops the scoreboard on every written word and checks burst shape.
    initial begin
        int wi = 0, rq_len = 0, ack_cyc = -10;
        logic [AW-1:0] burst_addr = '0;
        forever begin
            @(negedge clk);
            if (upload_done) done_cnt++;
            if (frame_error) err_cnt++;
            if (rd_en) begin
                rd_cnt++;
                check("rd_en_when_empty", queue_empty, 1'b0);
            end
            if (write_rq) begin
                rq_len++;
                rq_total++;
            end else if (rq_len != 0) begin
                check("write_rq_cycles", rq_len, ack_enable ? ack_delay : TO);
                rq_len = 0;
            end
            if (write_ack) ack_cyc = cyc;
            if (mem_wr_en) begin
                if (wi == 0) begin
                    check("wr_start_after_ack", cyc, ack_cyc + 1);
                    burst_addr = write_addr;
                    if (exp_addr.size() > 0) check("burst_addr", write_addr, exp_addr.pop_front());
                    else begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_burst: got addr 0x%0h, required none", write_addr);
                    end
                end else begin
                    check("addr_stable", write_addr, burst_addr);
                end
                if (exp_word.size() > 0) check($sformatf("word%0d", wi), write_data, exp_word.pop_front());
                else begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_word: got 0x%0h, required none", write_data);
                end
                wi++;
            end else if (wi != 0) begin
                check("burst_len", wi, BW);
                wi = 0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic start_frame(input logic [AW-1:0] base);
        @(negedge clk);
        base_addr = base;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for one upload_done, then confirms no second pulse and a drained scoreboard.
    task automatic wait_done(input string name, input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) @(posedge clk);
        repeat (10) @(posedge clk);
        check({name, "_done_pulses"}, done_cnt - d0, 1);
        check({name, "_words_left"}, exp_word.size(), 0);
        check({name, "_bursts_left"}, exp_addr.size(), 0);
    endtask

    task automatic push_frame(input int first_row0, input int first_row1);
        q.push_back(mark(0));
        q.push_back(mark(1));
        push_pixels(first_row0, FW);
        q.push_back(mark(1));
        push_pixels(first_row1, FW);
    endtask

    initial begin
        int e0, r0, w0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("rst_outputs", {rd_en, write_rq, mem_wr_en, upload_done, frame_error}, 5'b0);
        check("rst_addr", write_addr, 0);
        check("rst_data", write_data, 0);
        do_reset();

        // 1: two 32-pixel rows, 16 pixels per burst -> four bursts from 0x100, excess pixels stay queued.
        e0 = err_cnt;
        q.push_back(pix(16'h7777));
        push_frame(0, 32);
        push_pixels(1000, 2);
        expect_burst(21'h100, 0, 16);
        expect_burst(21'h108, 16, 16);
        expect_burst(21'h110, 32, 16);
        expect_burst(21'h118, 48, 16);
        start_frame(21'h100);
        wait_done("t1", 2000);
        check("t1_errors", err_cnt - e0, 0);
        check("t1_excess_left", q.size(), 2);
        q.delete();
        do_reset();

        // 2: slow arbiter; write_rq must stay up for the full delay.
`ifdef FRAME_UPLOADER_ACK_TIMEOUT_EN
        ack_delay = 12;
`else
        ack_delay = 50;
`endif
        push_frame(100, 132);
        expect_burst(21'h200, 100, 16);
        expect_burst(21'h208, 116, 16);
        expect_burst(21'h210, 132, 16);
        expect_burst(21'h218, 148, 16);
        start_frame(21'h200);
        wait_done("t2", 4000);
        ack_delay = 3;
        do_reset();

        // 3: short row of 20 pixels -> second burst holds 4 pixels then zero words, next row intact.
        e0 = err_cnt;
        q.push_back(mark(0));
        q.push_back(mark(1));
        push_pixels(0, 20);
        q.push_back(mark(1));
        push_pixels(200, 32);
        expect_burst(21'h000, 0, 16);
        expect_burst(21'h008, 16, 4);
        expect_burst(21'h010, 200, 16);
        expect_burst(21'h018, 216, 16);
        start_frame(21'h000);
        wait_done("t3", 2000);
        check("t3_error_pulses", err_cnt - e0, 1);
        do_reset();

        // 4: queue runs dry after 10 pixels for 100 cycles, then the frame completes.
        q.push_back(mark(0));
        q.push_back(mark(1));
        push_pixels(0, 10);
        expect_burst(21'h300, 0, 16);
        expect_burst(21'h308, 16, 16);
        expect_burst(21'h310, 32, 16);
        expect_burst(21'h318, 48, 16);
        start_frame(21'h300);
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        check("t4_drained", q.size(), 0);
        repeat (2) @(negedge clk);
        r0 = rd_cnt;
        w0 = rq_total;
        repeat (100) @(negedge clk);
        check("t4_no_rd_en", rd_cnt - r0, 0);
        check("t4_no_write_rq", rq_total - w0, 0);
        push_pixels(10, 22);
        q.push_back(mark(1));
        push_pixels(32, 32);
        wait_done("t4", 2000);
        do_reset();

        // 5: address counter wraps at 2^21.
        push_frame(500, 532);
        expect_burst(21'h1FFFF8, 500, 16);
        expect_burst(21'h000000, 516, 16);
        expect_burst(21'h000008, 532, 16);
        expect_burst(21'h000010, 548, 16);
        start_frame(21'h1FFFF8);
        wait_done("t5", 2000);
        do_reset();

`ifdef FRAME_UPLOADER_ACK_TIMEOUT_EN
        // 6: no ack -> abort after TO cycles of write_rq, then a fresh start works.
        e0 = err_cnt;
        r0 = done_cnt;
        ack_enable = 1'b0;
        q.push_back(mark(0));
        q.push_back(mark(1));
        push_pixels(0, 16);
        start_frame(21'h400);
        for (int i = 0; i < 300 && err_cnt == e0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("t6_error_pulses", err_cnt - e0, 1);
        check("t6_no_done", done_cnt - r0, 0);
        check("t6_write_rq_low", write_rq, 1'b0);
        ack_enable = 1'b1;
        push_frame(700, 732);
        expect_burst(21'h400, 700, 16);
        expect_burst(21'h408, 716, 16);
        expect_burst(21'h410, 732, 16);
        expect_burst(21'h418, 748, 16);
        start_frame(21'h400);
        wait_done("t6", 2000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required to finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
